// File: rtl/pn_stack_eval.sv
// Polish-notation evaluator: buffers one token packet, then runs it through a stack one
// token per cycle in prefix or postfix order, returning a signed result with an error code.
module pn_stack_eval #(
  parameter int DATA_W  = 32,
  parameter int OPD_W   = 3,
  parameter int MAX_TOK = 16,
  parameter int STK_D   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     operator,
  input  logic [OPD_W-1:0]         in,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out,
  output logic [2:0]               err_code
);

  localparam int CNT_W = $clog2(MAX_TOK + 1);
  localparam int SP_W  = $clog2(STK_D + 1);
  localparam int TOK_W = OPD_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_UNDER = 3'd1;
  localparam logic [2:0] E_LEFT  = 3'd2;
  localparam logic [2:0] E_TOK   = 3'd3;
  localparam logic [2:0] E_STK   = 3'd4;
  localparam logic [2:0] E_OPC   = 3'd5;

  function automatic logic signed [DATA_W-1:0] alu_op(
    input logic [2:0]               opc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sum;
    sum = a + b;
    case (opc)
      3'd0:    alu_op = sum;
      3'd1:    alu_op = a - b;
      3'd2:    alu_op = a * b;
      3'd3:    alu_op = sum[DATA_W-1] ? -sum : sum;
      3'd4:    alu_op = (a > b) ? a : b;
      3'd5:    alu_op = (a < b) ? a : b;
      default: alu_op = '0;
    endcase
  endfunction

  logic [2:0]               state_r, state_nx;
  logic                     mode_r, tok_ovf_r, has_opd_r, out_valid_r, in_ready_r;
  logic [CNT_W-1:0]         cnt_r, step_r, idx_s;
  logic [SP_W-1:0]          sp_r;
  // One spare slot in each array lets the full-width counters index them directly.
  logic [TOK_W-1:0]         buf_r [0:MAX_TOK];
  logic signed [DATA_W-1:0] stk_r [0:STK_D];
  logic signed [DATA_W-1:0] out_r, top_s, nxt_s, opa_s, opb_s, res_s;
  logic [2:0]               err_r, ev_err_s;
  logic                     xfer_s, full_s, last_step_s, tok_is_op_s;
  logic [OPD_W-1:0]         tok_val_s;

  // Current token decode, operand selection and per-token error detection.
  always_comb begin
    xfer_s      = in_valid & in_ready_r;
    full_s      = (cnt_r == CNT_W'(MAX_TOK));
    idx_s       = mode_r ? step_r : (cnt_r - CNT_W'(1) - step_r);
    tok_is_op_s = buf_r[idx_s][OPD_W];
    tok_val_s   = buf_r[idx_s][OPD_W-1:0];
    last_step_s = (step_r == (cnt_r - CNT_W'(1)));
    top_s       = stk_r[sp_r - SP_W'(1)];
    nxt_s       = stk_r[sp_r - SP_W'(2)];
    opa_s       = mode_r ? nxt_s : top_s;
    opb_s       = mode_r ? top_s : nxt_s;
    res_s       = alu_op(tok_val_s[2:0], opa_s, opb_s);
    // An operator-only packet never holds a value, so it reports as empty, not underflow.
    if (tok_is_op_s) begin
      if (sp_r < SP_W'(2)) begin
        ev_err_s = has_opd_r ? E_UNDER : E_LEFT;
      end else if (tok_val_s > OPD_W'(5)) begin
        ev_err_s = E_OPC;
      end else begin
        ev_err_s = E_OK;
      end
    end else if (sp_r == SP_W'(STK_D)) begin
      ev_err_s = E_STK;
    end else begin
      ev_err_s = E_OK;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: if (xfer_s) state_nx = in_last ? S_EVAL : S_LOAD; else state_nx = S_IDLE;
      S_LOAD: if (xfer_s && in_last) state_nx = (tok_ovf_r || full_s) ? S_DONE : S_EVAL;
              else state_nx = S_LOAD;
      S_EVAL: if (ev_err_s != E_OK) state_nx = S_DONE;
              else if (last_step_s) state_nx = S_CHK;
              else state_nx = S_EVAL;
      S_CHK:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE; else state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      err_r       <= E_OK;
      mode_r      <= 1'b0;
      cnt_r       <= '0;
      step_r      <= '0;
      sp_r        <= '0;
      tok_ovf_r   <= 1'b0;
      has_opd_r   <= 1'b0;
    end else begin
      state_r    <= state_nx;
      in_ready_r <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
      case (state_r)
        S_IDLE: if (xfer_s) begin
          mode_r    <= mode;
          cnt_r     <= CNT_W'(1);
          step_r    <= '0;
          sp_r      <= '0;
          tok_ovf_r <= 1'b0;
          has_opd_r <= ~operator;
        end
        S_LOAD: if (xfer_s) begin
          if (full_s) begin
            tok_ovf_r <= 1'b1;
          end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
            has_opd_r <= has_opd_r | ~operator;
          end
          if (in_last && (tok_ovf_r || full_s)) begin
            out_valid_r <= 1'b1;
            out_r       <= '0;
            err_r       <= E_TOK;
          end
        end
        S_EVAL: if (ev_err_s != E_OK) begin
          out_valid_r <= 1'b1;
          out_r       <= '0;
          err_r       <= ev_err_s;
        end else begin
          step_r <= step_r + CNT_W'(1);
          sp_r   <= tok_is_op_s ? (sp_r - SP_W'(1)) : (sp_r + SP_W'(1));
        end
        S_CHK: begin
          out_valid_r <= 1'b1;
          if (sp_r == SP_W'(1)) begin
            out_r <= stk_r[0];
            err_r <= E_OK;
          end else begin
            out_r <= '0;
            err_r <= E_LEFT;
          end
        end
        S_DONE: if (out_ready) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  // Token buffer and evaluation stack storage.
  always_ff @(posedge clk) begin
    if (xfer_s && (state_r == S_IDLE)) begin
      buf_r[0] <= {operator, in};
    end else if (xfer_s && (state_r == S_LOAD) && !full_s) begin
      buf_r[cnt_r] <= {operator, in};
    end
    if ((state_r == S_EVAL) && (ev_err_s == E_OK)) begin
      if (tok_is_op_s) begin
        stk_r[sp_r - SP_W'(2)] <= res_s;
      end else begin
        stk_r[sp_r] <= {{(DATA_W-OPD_W){1'b0}}, tok_val_s};
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign err_code  = err_r;

endmodule
